// File: rtl/div_sequencer.sv
// div_sequencer: front-end controller for the restoring divider.
// Accepts an operand pair, loads and starts the divider, waits for Done
// (or times out), and presents quotient/remainder on a valid/ready output.
// Divide-by-zero is answered directly without touching the divider.
module div_sequencer #(
  parameter int n       = 8,
  parameter int TIMEOUT = 32,
  parameter int TW      = 6
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_a,
  input  logic [n-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_q,
  output logic [n-1:0] out_r,
  output logic         out_dbz,
  output logic         out_timeout,
  output logic         busy,
  output logic         div_s,
  output logic         div_LA,
  output logic         div_EB,
  output logic [n-1:0] div_DataA,
  output logic [n-1:0] div_DataB,
  input  logic [n-1:0] div_Q,
  input  logic [n-1:0] div_R,
  input  logic         div_Done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    RELEASE = 3'd3,
    RESULT  = 3'd4
  } state_t;

  // Counter value on the last RUN cycle before giving up on the divider.
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nx;
  logic [TW-1:0]   cnt;
  logic            b_zero;

  assign b_zero = (in_b == '0);

  // State register with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    div_s     = 1'b0;
    div_LA    = 1'b0;
    div_EB    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = b_zero ? RESULT : LOAD;
      end
      LOAD: begin
        div_LA   = 1'b1;
        div_EB   = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        div_s = 1'b1;
        if (div_Done || (cnt == CNT_LAST)) state_nx = RELEASE;
      end
      RELEASE: begin
        state_nx = RESULT;
      end
      RESULT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operand, result, flag and timeout-counter registers.
  // Done is tested before the counter so a simultaneous Done wins over timeout.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt         <= '0;
      out_q       <= '0;
      out_r       <= '0;
      out_dbz     <= 1'b0;
      out_timeout <= 1'b0;
      div_DataA   <= '0;
      div_DataB   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (b_zero) begin
              out_q       <= '1;
              out_r       <= in_a;
              out_dbz     <= 1'b1;
              out_timeout <= 1'b0;
            end else begin
              div_DataA <= in_a;
              div_DataB <= in_b;
            end
          end
        end
        LOAD: begin
          cnt         <= '0;
          out_dbz     <= 1'b0;
          out_timeout <= 1'b0;
        end
        RUN: begin
          cnt <= cnt + TW'(1);
          if (div_Done) begin
            out_q <= div_Q;
            out_r <= div_R;
          end else if (cnt == CNT_LAST) begin
            out_q       <= '0;
            out_r       <= '0;
            out_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer with a behavioural divider model.
module tb_div_sequencer;

  localparam int N  = 8;
  localparam int TO = 32;

  logic         Clock = 1'b0;
  logic         Resetn;
  logic         in_valid, in_ready;
  logic [N-1:0] in_a, in_b;
  logic         out_valid, out_ready;
  logic [N-1:0] out_q, out_r;
  logic         out_dbz, out_timeout, busy;
  logic         div_s, div_LA, div_EB;
  logic [N-1:0] div_DataA, div_DataB;
  logic [N-1:0] div_Q, div_R;
  logic         div_Done;

  int errors = 0;
  int checks = 0;

  div_sequencer #(.n(N), .TIMEOUT(TO), .TW(6)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .out_dbz(out_dbz), .out_timeout(out_timeout), .busy(busy),
    .div_s(div_s), .div_LA(div_LA), .div_EB(div_EB),
    .div_DataA(div_DataA), .div_DataB(div_DataB),
    .div_Q(div_Q), .div_R(div_R), .div_Done(div_Done)
  );

  always #5 Clock = ~Clock;

  // Divider model: latches operands on LA/EB, raises Done lat cycles into s.
  int           m_lat  = 1;
  bit           m_stub = 1'b0;
  int           m_cnt;
  logic [N-1:0] m_a, m_b;

  always @(posedge Clock) begin
    if (!Resetn) begin
      m_cnt    <= 0;
      div_Done <= 1'b0;
      m_a      <= '0;
      m_b      <= '0;
    end else begin
      if (div_LA) m_a <= div_DataA;
      if (div_EB) m_b <= div_DataB;
      if (!div_s) begin
        m_cnt    <= 0;
        div_Done <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
        if (!m_stub && (m_cnt + 1 >= m_lat)) div_Done <= 1'b1;
      end
    end
  end

  assign div_Q = (m_b != 0) ? m_a / m_b : '1;
  assign div_R = (m_b != 0) ? m_a % m_b : m_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one operand pair in IDLE; returns after the accepting edge.
  task automatic accept(input int a, input int b, input int lat);
    int guard = 0;
    @(negedge Clock);
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge Clock);
      guard++;
    end
    check("idle_ready", in_ready, 1);
    m_stub   = (lat == 0);
    m_lat    = lat;
    in_a     = N'(a);
    in_b     = N'(b);
    in_valid = 1'b1;
    @(posedge Clock);
    #1 in_valid = 1'b0;
  endtask

  // Full transaction; lat==0 means divider never raises Done.
  task automatic run_txn(input int a, input int b, input int lat, input int hold);
    int runs, exp_runs, exp_q, exp_r, exp_dbz, exp_to;
    accept(a, b, lat);
    @(negedge Clock);
    if (b == 0) begin
      exp_q = 255; exp_r = a; exp_dbz = 1; exp_to = 0;
      check("dbz_nodiv", {div_LA, div_EB, div_s}, 0);
    end else begin
      check("load_la", div_LA, 1);
      check("load_eb", div_EB, 1);
      check("load_s", div_s, 0);
      check("load_busy", busy, 1);
      check("load_ready", in_ready, 0);
      runs = 0;
      @(negedge Clock);
      while (div_s === 1'b1 && runs < TO + 8) begin
        check("run_la_eb", {div_LA, div_EB}, 0);
        check("run_valid", out_valid, 0);
        runs++;
        @(negedge Clock);
      end
      exp_to   = (lat == 0 || lat + 1 > TO) ? 1 : 0;
      exp_runs = exp_to ? TO : lat + 1;
      check("run_len", runs, exp_runs);
      check("rel_valid", out_valid, 0);
      check("rel_busy", busy, 1);
      check("rel_ctrl", {div_LA, div_EB, div_s}, 0);
      @(negedge Clock);
      exp_q   = exp_to ? 0 : a / b;
      exp_r   = exp_to ? 0 : a % b;
      exp_dbz = 0;
    end
    for (int i = 0; i <= hold; i++) begin
      check("res_valid", out_valid, 1);
      check("res_q", out_q, exp_q);
      check("res_r", out_r, exp_r);
      check("res_dbz", out_dbz, exp_dbz);
      check("res_to", out_timeout, exp_to);
      check("res_ready", in_ready, 0);
      check("res_ctrl", {div_LA, div_EB, div_s}, 0);
      if (i < hold) begin
        in_valid = 1'b1;
        in_a     = N'($urandom);
        in_b     = N'($urandom);
        @(negedge Clock);
      end
    end
    out_ready = 1'b1;
    @(posedge Clock);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge Clock);
    check("done_valid", out_valid, 0);
    check("done_ready", in_ready, 1);
    check("done_busy", busy, 0);
  endtask

  initial begin
    int a, b, lat;
    Resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ctrl", {div_LA, div_EB, div_s}, 0);
    check("rst_q", out_q, 0);
    check("rst_r", out_r, 0);
    check("rst_flags", {out_dbz, out_timeout}, 0);
    check("rst_data", {div_DataA, div_DataB}, 0);
    Resetn = 1'b1;

    run_txn(30, 6, 3, 0);
    run_txn(120, 16, 5, 0);
    run_txn(50, 6, 2, 0);
    run_txn(77, 0, 1, 0);
    run_txn(200, 7, 8, 5);
    run_txn(99, 3, 0, 0);
    run_txn(100, 9, TO - 1, 0);
    run_txn(100, 9, TO, 1);

    // Reset in the middle of RUN.
    accept(30, 6, 10);
    repeat (4) @(negedge Clock);
    check("mid_running", div_s, 1);
    Resetn = 1'b0;
    @(posedge Clock);
    #1 Resetn = 1'b1;
    @(negedge Clock);
    check("mrst_s", div_s, 0);
    check("mrst_ready", in_ready, 1);
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_data", div_DataA, 0);
    run_txn(30, 6, 3, 0);

    for (int k = 0; k < 40; k++) begin
      a   = int'($urandom_range(0, 255));
      b   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 3));
      run_txn(a, b, lat, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
